// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM encoding and default NMI vector for irq_controller
package irq_pkg;
    typedef enum logic [2:0] {IDLE, REQ_IRQ, REQ_NMI, VEC, WAIT_REL} state_e;
    localparam logic [5:0] NMI_VEC_DEF = 6'h3F;
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: request/acknowledge/vector handshake between interrupt front-end and core
interface irq_controller_if #(parameter int VEC_W = 6);
    logic INT;
    logic NMI;
    logic INTD;
    logic INA;
    logic [VEC_W-1:0] vec;
    modport master (output INT, NMI, INTD, vec, input INA);
    modport slave (input INT, NMI, INTD, vec, output INA);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
module irq_prio_enc #(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 6
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic             valid_o,
    output logic [VEC_W-1:0] index_o
);
    always_comb begin
        valid_o = |req_i;
        index_o = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (req_i[i]) index_o = VEC_W'(i);
    end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt front-end with INA/INTD handshake
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 6,
    parameter logic [VEC_W-1:0] NMI_VEC = VEC_W'(NMI_VEC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             nmi_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    irq_controller_if.master bus,
    output logic [N_IRQ-1:0] pending
);
    logic [N_IRQ-1:0] irq_q, mask_q, pend_q, pend_d, clr;
    logic nmi_q, nmi_pend_q, nmi_pend_d;
    logic is_nmi_q, int_q, nmi_req_q, intd_q, win_valid;
    logic [VEC_W-1:0] sel_q, vec_q, win_idx;
    state_e state_q;

    irq_prio_enc #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) u_enc (
        .req_i  (pend_q & mask_q),
        .valid_o(win_valid),
        .index_o(win_idx)
    );

    // new edges are ORed in after the clear so a same-cycle re-trigger survives
    assign clr = (state_q == VEC && !is_nmi_q) ? N_IRQ'(1) << sel_q : '0;
    assign pend_d = (pend_q & ~clr) | (irq & ~irq_q);
    assign nmi_pend_d = (nmi_pend_q & ~(state_q == VEC && is_nmi_q)) | (nmi_in & ~nmi_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q      <= '0;
            nmi_q      <= 1'b0;
            pend_q     <= '0;
            nmi_pend_q <= 1'b0;
            mask_q     <= '0;
        end else begin
            irq_q      <= irq;
            nmi_q      <= nmi_in;
            pend_q     <= pend_d;
            nmi_pend_q <= nmi_pend_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_nmi_q  <= 1'b0;
            sel_q     <= '0;
            int_q     <= 1'b0;
            nmi_req_q <= 1'b0;
            intd_q    <= 1'b0;
            vec_q     <= '0;
        end else begin
            intd_q <= 1'b0;
            vec_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (nmi_pend_q) begin
                        state_q   <= REQ_NMI;
                        is_nmi_q  <= 1'b1;
                        nmi_req_q <= 1'b1;
                    end else if (win_valid) begin
                        state_q  <= REQ_IRQ;
                        is_nmi_q <= 1'b0;
                        sel_q    <= win_idx;
                        int_q    <= 1'b1;
                    end
                end
                REQ_IRQ, REQ_NMI: begin
                    if (bus.INA) begin
                        state_q   <= VEC;
                        int_q     <= 1'b0;
                        nmi_req_q <= 1'b0;
                        intd_q    <= 1'b1;
                        vec_q     <= is_nmi_q ? NMI_VEC : sel_q;
                    end
                end
                VEC: state_q <= WAIT_REL;
                WAIT_REL: if (!bus.INA) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.INT  = int_q;
    assign bus.NMI  = nmi_req_q;
    assign bus.INTD = intd_q;
    assign bus.vec  = vec_q;
    assign pending  = pend_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vectors for irq_controller
module tb_irq_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nmi_in = 1'b0;
    logic mask_we = 1'b0;
    logic [7:0] irq = '0;
    logic [7:0] mask_wdata = '0;
    logic [7:0] pending;
    logic seen;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int t_last = 0;
    int t1 = 0;

    irq_controller_if #(.VEC_W(6)) bus ();

    irq_controller #(.N_IRQ(8), .VEC_W(6), .NMI_VEC(6'h3F)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .nmi_in    (nmi_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .bus       (bus),
        .pending   (pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input logic [7:0] m);
        mask_wdata = m;
        mask_we = 1'b1;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v, input logic n);
        irq = v;
        nmi_in = n;
        step();
        irq = '0;
        nmi_in = 1'b0;
    endtask

    // waits for the request, acks after dly cycles, checks the strobe; retrig lands on the clear edge
    task automatic serve(input string tag, input logic exp_nmi, input logic [5:0] exp_vec,
                         input int dly, input logic [7:0] retrig);
        int t = 0;
        while (!(exp_nmi ? bus.NMI : bus.INT) && t < 50) begin
            step();
            t++;
        end
        chk({tag, "_req"}, 32'(exp_nmi ? bus.NMI : bus.INT), 1);
        chk({tag, "_other"}, 32'(exp_nmi ? bus.INT : bus.NMI), 0);
        repeat (dly) step();
        bus.INA = 1'b1;
        step();
        t_last = cyc;
        chk({tag, "_intd"}, 32'(bus.INTD), 1);
        chk({tag, "_vec"}, 32'(bus.vec), 32'(exp_vec));
        chk({tag, "_req_drop"}, 32'(bus.INT | bus.NMI), 0);
        bus.INA = 1'b0;
        irq = retrig;
        step();
        irq = '0;
        chk({tag, "_intd_1cyc"}, 32'(bus.INTD), 0);
    endtask

    initial begin
        bus.INA = 1'b0;
        step();
        step();
        chk("rst_int", 32'(bus.INT), 0);
        chk("rst_nmi", 32'(bus.NMI), 0);
        chk("rst_intd", 32'(bus.INTD), 0);
        chk("rst_vec", 32'(bus.vec), 0);
        chk("rst_pend", 32'(pending), 0);
        rst = 1'b0;

        wr_mask(8'h04);
        pulse(8'h04, 1'b0);
        chk("s1_pend", 32'(pending), 32'h04);
        chk("s1_int_early", 32'(bus.INT), 0);
        step();
        chk("s1_int_lat", 32'(bus.INT), 1);
        serve("s1", 1'b0, 6'd2, 3, 8'h00);
        chk("s1_pend_clr", 32'(pending), 0);
        chk("s1_int_low", 32'(bus.INT), 0);

        wr_mask(8'hFF);
        pulse(8'h22, 1'b0);
        serve("s2a", 1'b0, 6'd1, 1, 8'h00);
        t1 = t_last;
        serve("s2b", 1'b0, 6'd5, 0, 8'h00);
        chk("s2_gap", 32'((t_last - t1) >= 4), 1);
        chk("s2_pend_clr", 32'(pending), 0);

        wr_mask(8'h00);
        pulse(8'h08, 1'b0);
        step();
        step();
        chk("s3_int_masked", 32'(bus.INT), 0);
        chk("s3_pend", 32'(pending), 32'h08);
        wr_mask(8'h08);
        chk("s3_int_mask_edge", 32'(bus.INT), 0);
        step();
        chk("s3_int_after_mask", 32'(bus.INT), 1);
        serve("s3", 1'b0, 6'd3, 1, 8'h00);

        wr_mask(8'h01);
        pulse(8'h01, 1'b1);
        step();
        chk("s4_nmi_first", 32'(bus.NMI), 1);
        serve("s4n", 1'b1, 6'h3F, 1, 8'h00);
        serve("s4i", 1'b0, 6'd0, 1, 8'h00);
        chk("s4_pend_clr", 32'(pending), 0);

        wr_mask(8'h10);
        pulse(8'h10, 1'b0);
        serve("s5a", 1'b0, 6'd4, 1, 8'h10);
        chk("s5_pend_kept", 32'(pending), 32'h10);
        serve("s5b", 1'b0, 6'd4, 1, 8'h00);
        chk("s5_pend_clr", 32'(pending), 0);

        wr_mask(8'h02);
        pulse(8'h02, 1'b0);
        step();
        chk("s6_int", 32'(bus.INT), 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_int_async", 32'(bus.INT), 0);
        chk("s6_pend_async", 32'(pending), 0);
        chk("s6_intd_async", 32'(bus.INTD), 0);
        step();
        step();
        rst = 1'b0;
        bus.INA = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | bus.INTD | bus.INT | bus.NMI;
        end
        chk("s6_no_intd", 32'(seen), 0);
        bus.INA = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Upstream interrupt front-end for the multicycle MIPS core. It collects N external IRQ lines and one non-maskable source, latches edges into pending state, applies a software mask and a fixed priority, and runs the request/acknowledge handshake with the core. The core receives INT, NMI and INTD, and returns INA. On acknowledge the block presents a vector for exactly one cycle with INTD as its strobe.

Parameters:
N_IRQ, 8, number of maskable IRQ lines (1..32)
VEC_W, 6, vector width; must satisfy 2^VEC_W > N_IRQ
NMI_VEC, 6'h3F, vector presented for NMI; must not collide with 0..N_IRQ-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
irq  in  N_IRQ  maskable requests, synchronous to clk, rising-edge sensitive
nmi_in  in  1  non-maskable request, synchronous to clk, rising-edge sensitive
mask_we  in  1  mask write strobe
mask_wdata  in  N_IRQ  new mask; bit=1 enables the line
INA  in  1  interrupt acknowledge from the core (level)
INT  out  1  maskable interrupt request to the core
NMI  out  1  non-maskable request to the core
INTD  out  1  vector-valid strobe, one cycle
vec  out  VEC_W  vector, valid only while INTD=1
pending  out  N_IRQ  raw pending bits, for status readback

Behaviour:
- Reset (async, rst=1): INT=0, NMI=0, INTD=0, vec=0, pending=0, nmi_pend=0, mask=0 (all lines disabled), edge registers=0, state=IDLE. Reset asserted mid-handshake aborts the handshake immediately with no vector.
- Edge detect: irq_q/nmi_q register the previous input. A rise is `irq & ~irq_q`; pending[i] sets on the clock edge where the rise is seen. Masked lines still latch pending.
- Set/clear collision on the same bit in the same cycle: set wins, so the new edge is not lost.
- mask_we writes mask on the next edge. A mask change never cancels a request already committed to the core.
- Priority: nmi_pend first. Otherwise the lowest index i with pending[i]&mask[i] wins.
- FSM:
  - IDLE:
    - if nmi_pend, go to REQ_NMI and set is_nmi=1.
    - else if any pending[i]&mask[i], go to REQ_IRQ and latch the winner index into sel.
    - else stay in IDLE.
  - REQ_IRQ: INT=1. Hold until INA=1 is sampled, then go to VEC.
  - REQ_NMI: NMI=1. Hold until INA=1 is sampled, then go to VEC.
  - VEC (one cycle):
    - INT=0, NMI=0, INTD=1.
    - vec = is_nmi ? NMI_VEC : sel zero-extended.
    - Clear nmi_pend or pending[sel] at the end of the cycle, subject to the set-wins rule.
    - Then go to WAIT_REL.
  - WAIT_REL: wait until INA=0 is sampled, then go to IDLE. New edges keep latching during this state.
- An NMI edge arriving during REQ_IRQ does not pre-empt it. It is served on the next IDLE pass.
- Latency:
  - irq rise sampled at edge k gives pending at k and INT high after edge k+1.
  - INA sampled high at edge m gives INTD high after edge m, for exactly one cycle.
- Outputs are registered; INT, NMI and INTD are never high together.
- INA high while in IDLE is ignored.
- Back-to-back service: minimum 4 cycles between consecutive INTD pulses.

Decomposition:
- Shared package irq_pkg: FSM state encoding (IDLE, REQ_IRQ, REQ_NMI, VEC, WAIT_REL) and the default NMI_VEC constant.
- One sub-module, irq_prio_enc: combinational lowest-index-first encoder, N_IRQ in, outputs {valid, index[VEC_W-1:0]}.

Test Plan:
- Reset, then mask_wdata=8'h04 and pulse irq[2]; INA rises 3 cycles after INT -> INT high 2 cycles after irq rise, INTD=1 for one cycle with vec=2, pending[2] cleared, INT low.
- Mask=8'hFF, irq[5] and irq[1] rise in the same cycle -> first service gives vec=1, second gives vec=5; INTD pulses at least 4 cycles apart.
- mask=0, pulse irq[3] -> INT stays 0 and pending=8'h08. Then write mask=8'h08 -> INT rises 1 cycle after the mask edge, and service gives vec=3.
- nmi_in and irq[0] rise together with mask=8'h01 -> NMI asserted first, vec=6'h3F. Then INT is served with vec=0.
- irq[4] re-rises on the exact cycle of its VEC clear -> pending[4] stays 1 and a second service gives vec=4.
- rst asserted while in REQ_IRQ with INT=1 -> INT=0 asynchronously, pending=0, no INTD pulse after reset releases.
